// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared definitions for the decode hazard controller: instruction field slices,
// opcode encodings and the decode sequencing FSM states.
package decode_hazard_ctrl_pkg;

   localparam int unsigned INST_W = 16;
   localparam int unsigned REG_AW = 4;
   localparam int unsigned CNT_W  = 2;

   localparam int unsigned OP_MSB  = 15;
   localparam int unsigned OP_LSB  = 12;
   localparam int unsigned RS1_MSB = 11;
   localparam int unsigned RS1_LSB = 8;
   localparam int unsigned RS2_MSB = 7;
   localparam int unsigned RS2_LSB = 4;
   localparam int unsigned RD_MSB  = 3;
   localparam int unsigned RD_LSB  = 0;

   localparam logic [3:0] OP_ALU  = 4'h1;
   localparam logic [3:0] OP_ALUI = 4'h2;
   localparam logic [3:0] OP_BR   = 4'hC;
   localparam logic [3:0] OP_ST   = 4'hD;

   // Opcodes that never write rd (branches, stores).
   localparam logic [15:0] NO_WB_OPS = (16'(1) << OP_BR) | (16'(1) << OP_ST);

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

endpackage

// File: rtl/decode_hazard_ctrl_scoreboard.sv
// hazard_scoreboard: one pending-write bit per register, cleared by writeback and
// set by issue; exposes the pending bits of the three decode operand fields.
module hazard_scoreboard #(
   parameter int unsigned NREG = 16,
   parameter int unsigned AW   = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clr_en,
   input  logic [AW-1:0]   clr_addr,
   input  logic            set_en,
   input  logic [AW-1:0]   set_addr,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   input  logic [AW-1:0]   rd,
   output logic [NREG-1:0] busy,
   output logic            busy_rs1,
   output logic            busy_rs2,
   output logic            busy_rd
);

   logic [NREG-1:0] clr_mask;
   logic [NREG-1:0] set_mask;

   always_comb begin
      clr_mask = '0;
      set_mask = '0;
      if (clr_en) clr_mask = NREG'(1) << clr_addr;
      if (set_en) set_mask = NREG'(1) << set_addr;
   end

   // Clear applied before set so a new writer of the retiring register keeps it busy.
   always_ff @(posedge clk) begin
      if (!reset) busy <= '0;
      else        busy <= (busy & ~clr_mask) | set_mask;
   end

   assign busy_rs1 = busy[rs1];
   assign busy_rs2 = busy[rs2];
   assign busy_rd  = busy[rd];

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard control: scoreboard-based stalls, EX forward selects and
// post-branch fetch flush. Optional EX forwarding enabled by DECODE_FORWARD_EN.
module decode_hazard_ctrl
   import decode_hazard_ctrl_pkg::*;
#(
   parameter int unsigned NREG       = 16,
   parameter int unsigned BR_PENALTY = 1,
   parameter logic [15:0] WB_OPMASK  = 16'hFFFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              validD,
   input  logic [INST_W-1:0] instD,
   input  logic              immediateC,
   input  logic              branch_takenD,
   input  logic              write_en,
   input  logic [REG_AW-1:0] destAddW,
   input  logic              forwardE,
   input  logic [REG_AW-1:0] forward_addE,
   output logic              issueD,
   output logic              stallF,
   output logic              stallD,
   output logic              flushD,
   output logic              flushE,
   output logic              fwd_selA,
   output logic              fwd_selB,
   output logic [NREG-1:0]   busy_regs
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         op;
   logic [REG_AW-1:0]  rs1, rs2, rd;
   logic [NREG-1:0]    busy;
   logic               busy_rs1, busy_rs2, busy_rd;
   logic               hit_a, hit_b, hit_d;
   logic               wb_a, wb_b, wb_d;
   logic               fw_a, fw_b;
   logic               unsat;
   logic               writes_rd;
   logic               set_en;

   assign op  = instD[OP_MSB:OP_LSB];
   assign rs1 = instD[RS1_MSB:RS1_LSB];
   assign rs2 = instD[RS2_MSB:RS2_LSB];
   assign rd  = instD[RD_MSB:RD_LSB];

   assign writes_rd = WB_OPMASK[op];
   assign set_en    = issueD & writes_rd;

   hazard_scoreboard #(
      .NREG (NREG),
      .AW   (REG_AW)
   ) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .clr_en   (write_en),
      .clr_addr (destAddW),
      .set_en   (set_en),
      .set_addr (rd),
      .rs1      (rs1),
      .rs2      (rs2),
      .rd       (rd),
      .busy     (busy),
      .busy_rs1 (busy_rs1),
      .busy_rs2 (busy_rs2),
      .busy_rd  (busy_rd)
   );

   assign hit_a = busy_rs1;
   assign hit_b = busy_rs2 & ~immediateC;
   assign hit_d = busy_rd & writes_rd;

   // Register-file bypass: the WB write this cycle resolves a pending hit.
   assign wb_a = write_en & (destAddW == rs1);
   assign wb_b = write_en & (destAddW == rs2);
   assign wb_d = write_en & (destAddW == rd);

`ifdef DECODE_FORWARD_EN
   assign fw_a = hit_a & forwardE & (forward_addE == rs1);
   assign fw_b = hit_b & forwardE & (forward_addE == rs2);
`else
   logic unused_fwd;
   assign unused_fwd = ^{forwardE, forward_addE};
   assign fw_a = 1'b0;
   assign fw_b = 1'b0;
`endif

   // WAW hits are only resolved by writeback, never by the EX forward path.
   assign unsat = (hit_a & ~wb_a & ~fw_a) |
                  (hit_b & ~wb_b & ~fw_b) |
                  (hit_d & ~wb_d);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      issueD   = 1'b0;
      stallD   = 1'b0;
      stallF   = 1'b0;
      flushD   = 1'b0;
      flushE   = 1'b0;
      fwd_selA = 1'b0;
      fwd_selB = 1'b0;

      case (state_q)
         RUN: begin
            stallD   = validD & unsat;
            stallF   = stallD;
            flushE   = stallD;
            issueD   = validD & ~stallD;
            fwd_selA = validD & fw_a;
            fwd_selB = validD & fw_b;
            if (issueD && branch_takenD) begin
               state_d = FLUSH;
               cnt_d   = CNT_W'(BR_PENALTY - 1);
            end
         end
         FLUSH: begin
            flushD = 1'b1;
            if (cnt_q == '0) state_d = RUN;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: state_d = RUN;
      endcase

      // Everything is quiet while reset is held low.
      if (!reset) begin
         issueD   = 1'b0;
         stallD   = 1'b0;
         stallF   = 1'b0;
         flushD   = 1'b0;
         flushE   = 1'b0;
         fwd_selA = 1'b0;
         fwd_selB = 1'b0;
      end
   end

   assign busy_regs = reset ? busy : '0;

endmodule
